// File: rtl/frame_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_timing_pkg
// Description : Shared frame-timing constants and monitor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_timing_pkg;

   // Tick generators count 0..FRAME_RATE_CYCLES, giving NOMINAL_PERIOD cycles per frame
   localparam int FRAME_RATE_CYCLES = 416666;
   localparam int NOMINAL_PERIOD    = 416667;

   localparam int DEFAULT_CNT_W     = 26;
   localparam int DEFAULT_TOL       = 64;
   localparam int DEFAULT_TIMEOUT   = 833334;

   localparam int FRAME_COUNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOST    = 2'd2
   } monitor_state_t;

endpackage : frame_timing_pkg
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Registered history bit with combinational rising-edge output.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig_in,
   output logic rise
);

   logic r_prev;

   // History is never cleared synchronously so a held-high level is not re-detected
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= 1'b0;
      end else begin
         r_prev <= sig_in;
      end
   end

   assign rise = sig_in & ~r_prev;

endmodule : rise_detect
`default_nettype wire

// File: rtl/frame_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : frame_period_monitor
// Description : Measures cycles between frame pulses; min/max, count, loss flag.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_period_monitor
   import frame_timing_pkg::*;
#(
   parameter int CNT_W   = DEFAULT_CNT_W,
   parameter int NOMINAL = NOMINAL_PERIOD,
   parameter int TOL     = DEFAULT_TOL,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pulse_in,
   input  logic                     clear,
   output logic [CNT_W-1:0]         period,
   output logic                     period_valid,
   output logic [CNT_W-1:0]         min_period,
   output logic [CNT_W-1:0]         max_period,
   output logic [FRAME_COUNT_W-1:0] frame_count,
   output logic                     in_tol,
   output logic                     timeout
);

   localparam logic [CNT_W-1:0]         c_one          = CNT_W'(1);
   localparam logic [CNT_W-1:0]         c_timeout_last = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W:0]           c_nominal      = (CNT_W+1)'(NOMINAL);
   localparam logic [CNT_W:0]           c_tol          = (CNT_W+1)'(TOL);
   localparam logic [FRAME_COUNT_W-1:0] c_frame_inc    = FRAME_COUNT_W'(1);

   monitor_state_t   r_state;
   logic [CNT_W-1:0] r_elapsed;

   logic             w_event;
   logic [CNT_W-1:0] w_period;
   logic [CNT_W:0]   w_diff;
   logic [CNT_W:0]   w_abs_diff;
   logic             w_in_tol;

   rise_detect u_rise_detect (
      .clk    (clk),
      .reset  (reset),
      .sig_in (pulse_in),
      .rise   (w_event)
   );

   // In MEASURE elapsed never exceeds TIMEOUT-1, so +1 cannot overflow here
   assign w_period = r_elapsed + c_one;

   // Deviation is taken one bit wider than the counter so it is always representable
   always_comb begin
      w_diff     = {1'b0, w_period} - c_nominal;
      w_abs_diff = w_diff[CNT_W] ? (~w_diff + {{CNT_W{1'b0}}, 1'b1}) : w_diff;
      w_in_tol   = (w_abs_diff <= c_tol);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_elapsed    <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         min_period   <= '1;
         max_period   <= '0;
         frame_count  <= '0;
         in_tol       <= 1'b0;
         timeout      <= 1'b0;
      end else if (clear) begin
         // A coincident edge is intentionally dropped
         r_state      <= IDLE;
         r_elapsed    <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         min_period   <= '1;
         max_period   <= '0;
         frame_count  <= '0;
         in_tol       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;

         if (w_event) begin
            r_elapsed <= '0;
         end else if (r_elapsed != '1) begin
            r_elapsed <= r_elapsed + c_one;
         end

         case (r_state)
            IDLE: begin
               if (w_event) begin
                  r_state     <= MEASURE;
                  frame_count <= frame_count + c_frame_inc;
               end
            end

            MEASURE: begin
               if (w_event) begin
                  period       <= w_period;
                  period_valid <= 1'b1;
                  in_tol       <= w_in_tol;
                  frame_count  <= frame_count + c_frame_inc;
                  if (w_period < min_period) begin
                     min_period <= w_period;
                  end
                  if (w_period > max_period) begin
                     max_period <= w_period;
                  end
               end else if (r_elapsed == c_timeout_last) begin
                  r_state <= LOST;
                  timeout <= 1'b1;
               end
            end

            LOST: begin
               // Interval spanning the loss is meaningless, so no period is reported
               if (w_event) begin
                  r_state     <= MEASURE;
                  timeout     <= 1'b0;
                  frame_count <= frame_count + c_frame_inc;
               end
            end

            default: begin
               r_state <= IDLE;
               timeout <= 1'b0;
            end
         endcase
      end
   end

endmodule : frame_period_monitor
`default_nettype wire

// File: doc/frame_period_monitor.md
# frame_period_monitor

Receive-side companion to the frame-tick generators: consumes a frame pulse stream (120 fps tick or frames-per-pulse output) and measures the clock-cycle interval between pulses. Reports each measured period with a one-cycle strobe, tracks min/max, counts frames, and flags out-of-tolerance and missing pulses. Sits beside the game-logic timing path for on-board self-check and debug display.

## Interface
- CNT_W, 26, width of interval counter and all period outputs
- NOMINAL, 416667, expected cycles between pulses (120 fps at 50 MHz)
- TOL, 64, allowed absolute deviation from NOMINAL for in_tol
- TIMEOUT, 833334, cycles without a pulse before declaring loss (must be < 2^CNT_W)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state to reset values
- pulse_in  in  1  frame pulse (level; rising edges are events)
- clear  in  1  synchronous clear of statistics and state
- period  out  CNT_W  last measured interval in cycles
- period_valid  out  1  one-cycle strobe when period updates
- min_period  out  CNT_W  smallest reported period since reset/clear
- max_period  out  CNT_W  largest reported period since reset/clear
- frame_count  out  16  accepted rising edges since reset/clear, wraps
- in_tol  out  1  |period − NOMINAL| ≤ TOL, updated with period
- timeout  out  1  high while in LOST state

## Operation
- Event = rising edge of pulse_in (pulse_in high, registered previous value low). A level held high for many cycles is one event.
- Reset values: period=0, period_valid=0, min_period=all-ones, max_period=0, frame_count=0, in_tol=0, timeout=0, state IDLE, elapsed=0, prev=0.
- elapsed: set to 0 on every event cycle, otherwise increments, saturating at all-ones.
- States:
  - IDLE: waiting for first event. Event → MEASURE, frame_count+1, no period reported.
  - MEASURE: event → period=elapsed+1, period_valid=1, min/max/in_tol update, frame_count+1, stay. elapsed reaches TIMEOUT−1 with no event → LOST.
  - LOST: timeout=1. Event → MEASURE, frame_count+1, no period reported (interval invalid), timeout deasserts.
- Period semantics: events at cycles t0, t1 → period=t1−t0. Back-to-back edges are impossible (minimum period 2).
- min/max compare against the new period in the same update; the first reported period after reset/clear sets both.
- in_tol: compute difference at CNT_W+1 bits, signed; no wrap errors.
- clear: returns all outputs and state to reset values except prev, which keeps tracking pulse_in. Clear wins over a simultaneous event (the event is dropped).
- Reset mid-measurement: discard everything; the next event is treated as a first event.

## Timing
- Edge detect is combinational from pulse_in and prev; all outputs registered.
- period, period_valid, in_tol, min/max, frame_count valid on the cycle after the rising edge (latency 1).
- timeout asserts the cycle after elapsed reaches TIMEOUT−1 (TIMEOUT cycles after the last event) and deasserts the cycle after the next event.
- period_valid is never high two consecutive cycles.

## Structure
- Shared package frame_timing_pkg: FRAME_RATE_CYCLES (416666), NOMINAL_PERIOD (416667), state encoding (IDLE, MEASURE, LOST). The tick generators use the same constants.
- Sub-module rise_detect (registered prev, combinational edge output).

## Test plan
Bench parameters: CNT_W=8, NOMINAL=10, TOL=1, TIMEOUT=20.
- Reset, then 1-cycle pulses every 10 cycles ×4 → first event gives no strobe; 3 strobes with period=10, in_tol=1, min=max=10, frame_count=4.
- Pulse intervals 9, 12, 11 → periods 9, 12, 11; in_tol 1, 0, 1; min=9, max=12.
- pulse_in held high 15 cycles, low 5, then high → one event per rising edge, period=20, frame_count+1 per edge only.
- Stop pulses after an event → timeout=1 exactly 20 cycles later; next pulse clears timeout, no period_valid; following pulse 10 cycles later gives period=10.
- clear asserted on the same cycle as a rising edge → all stats at reset values, frame_count=0, state IDLE; next edge counts as first (no strobe).
- Async reset asserted mid-interval (between clock edges) → outputs at reset values immediately; behaviour afterwards matches the first scenario.
